burst_req_fifo: RTL and testbench

//  Single-clock, request-driven burst FIFO: the generalised successor of the two-clock bridge request/valid flow.
//  A consumer pulses a burst request with a length; the block raises data_req_clka toward the producer and

---
 rtl/burst_req_fifo.sv | 124 ++++++++++++
 tb/tb_burst_req_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_req_fifo.sv
// Request-driven burst FIFO: a consumer requests N words, the producer is throttled
// on almost-full, and words drain through a first-word-fall-through valid/ready port.
module burst_req_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int LEN_W     = 6,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clka,
    input  logic                     reset_clka,
    input  logic                     burst_req_clka,
    input  logic [LEN_W-1:0]         burst_len_clka,
    output logic                     data_req_clka,
    input  logic                     data_valid_clka,
    input  logic [DATA_W-1:0]        din_clka,
    output logic                     dout_valid_clka,
    input  logic                     dout_ready_clka,
    output logic [DATA_W-1:0]        dout_clka,
    output logic [$clog2(DEPTH):0]   count_clka,
    output logic                     burst_done_clka,
    output logic [2:0]               err_clka,
    input  logic                     clear_err_clka
);

    // state | meaning
    // IDLE  | no burst open; producer writes are stray and dropped
    // FILL  | burst open; accepting words until remaining reaches zero

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(AF_MARGIN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    free;
    logic [LEN_W-1:0]    remaining;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [2:0]          err_q;
    logic [2:0]          err_new;
    logic                done_q;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign free    = DEPTH_C - count_q;
    assign push    = (state == FILL) && data_valid_clka && !full;
    assign pop     = !empty && dout_ready_clka;

    // {req_collision, stray_write, overflow}
    assign err_new = {burst_req_clka && (state == FILL),
                      data_valid_clka && (state == IDLE),
                      data_valid_clka && (state == FILL) && full};

    assign data_req_clka   = (state == FILL) && (free > MARGIN_C);
    assign dout_valid_clka = !empty;
    assign dout_clka       = empty ? '0 : mem[rd_ptr];
    assign count_clka      = count_q;
    assign burst_done_clka = done_q;
    assign err_clka        = err_q;

    always_ff @(posedge clka or posedge reset_clka) begin
        if (reset_clka) begin
            state     <= IDLE;
            remaining <= '0;
            done_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            err_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_req_clka && (burst_len_clka != '0)) begin
                        state     <= FILL;
                        remaining <= burst_len_clka;
                    end
                end
                FILL: begin
                    if (push) begin
                        remaining <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase

            // a new error in the clearing cycle survives the clear
            if (clear_err_clka) err_q <= err_new;
            else                err_q <= err_q | err_new;
        end
    end

    always_ff @(posedge clka) begin
        if (push) mem[wr_ptr] <= din_clka;
    end

endmodule

// File: tb/tb_burst_req_fifo.sv
// Directed bench for burst_req_fifo: expected words go into a queue as they are
// written, and a negedge monitor compares each word the sink accepts.
module tb_burst_req_fifo;

    logic        clka = 1'b0;
    logic        reset_clka;
    logic        burst_req_clka;
    logic [5:0]  burst_len_clka;
    logic        data_req_clka;
    logic        data_valid_clka;
    logic [7:0]  din_clka;
    logic        dout_valid_clka;
    logic        dout_ready_clka;
    logic [7:0]  dout_clka;
    logic [4:0]  count_clka;
    logic        burst_done_clka;
    logic [2:0]  err_clka;
    logic        clear_err_clka;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];

    burst_req_fifo #(.DATA_W(8), .DEPTH(16), .LEN_W(6), .AF_MARGIN(2)) dut (
        .clka            (clka),
        .reset_clka      (reset_clka),
        .burst_req_clka  (burst_req_clka),
        .burst_len_clka  (burst_len_clka),
        .data_req_clka   (data_req_clka),
        .data_valid_clka (data_valid_clka),
        .din_clka        (din_clka),
        .dout_valid_clka (dout_valid_clka),
        .dout_ready_clka (dout_ready_clka),
        .dout_clka       (dout_clka),
        .count_clka      (count_clka),
        .burst_done_clka (burst_done_clka),
        .err_clka        (err_clka),
        .clear_err_clka  (clear_err_clka)
    );

    always #5 clka = ~clka;

    // Monitor: a word is consumed at the next posedge whenever valid & ready hold here.
    always @(negedge clka) begin
        logic [7:0] w;
        if (!reset_clka && dout_valid_clka && dout_ready_clka) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got word %0h but no word expected", dout_clka);
            end else begin
                w = exp_q.pop_front();
                if (dout_clka !== w) begin
                    errors++;
                    $display("FAIL sb_data: got %0h expected %0h", dout_clka, w);
                end
            end
        end
        if (burst_done_clka === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic start_burst(input int len);
        burst_req_clka = 1'b1;
        burst_len_clka = 6'(len);
        tick();
        burst_req_clka = 1'b0;
    endtask

    task automatic put_word(input logic [7:0] w, input bit honor, input bit expect_acc);
        int n = 0;
        if (honor) begin
            while (!data_req_clka && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) chk("data_req_timeout", 0, 1);
        end
        data_valid_clka = 1'b1;
        din_clka        = w;
        if (expect_acc) exp_q.push_back(w);
        tick();
        data_valid_clka = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        dout_ready_clka = 1'b1;
        while (count_clka != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", int'(n < 300), 1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic do_clear();
        clear_err_clka = 1'b1;
        tick();
        clear_err_clka = 1'b0;
    endtask

    initial begin
        int d0;
        reset_clka      = 1'b1;
        burst_req_clka  = 1'b0;
        burst_len_clka  = '0;
        data_valid_clka = 1'b0;
        din_clka        = '0;
        dout_ready_clka = 1'b0;
        clear_err_clka  = 1'b0;
        tick();
        tick();
        reset_clka = 1'b0;
        tick();

        chk("rst_count", count_clka, 0);
        chk("rst_dout_valid", dout_valid_clka, 0);
        chk("rst_dout", dout_clka, 0);
        chk("rst_data_req", data_req_clka, 0);
        chk("rst_done", burst_done_clka, 0);
        chk("rst_err", err_clka, 0);

        // zero-length request is ignored
        start_burst(0);
        chk("len0_data_req", data_req_clka, 0);

        // T1: len 5, sink always ready
        dout_ready_clka = 1'b1;
        d0 = done_cnt;
        start_burst(5);
        chk("t1_data_req", data_req_clka, 1);
        put_word(8'd1, 1'b1, 1'b1);
        chk("t1_fwft_valid", dout_valid_clka, 1);
        chk("t1_fwft_data", dout_clka, 1);
        for (int i = 2; i <= 5; i++) put_word(8'(i), 1'b1, 1'b1);
        tick(); tick(); tick();
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_req_low", data_req_clka, 0);
        drain();

        // T2: len 21, sink stalled until almost-full throttles the producer
        dout_ready_clka = 1'b0;
        d0 = done_cnt;
        start_burst(21);
        for (int i = 0; i < 14; i++) put_word(8'(i), 1'b1, 1'b1);
        chk("t2_af_count", count_clka, 14);
        chk("t2_af_req", data_req_clka, 0);
        dout_ready_clka = 1'b1;
        for (int i = 14; i < 21; i++) put_word(8'(i), 1'b1, 1'b1);
        tick(); tick();
        chk("t2_done_once", done_cnt - d0, 1);
        drain();

        // T3: stray write while idle
        put_word(8'hAA, 1'b0, 1'b0);
        chk("t3_count", count_clka, 0);
        chk("t3_err", err_clka, 3'b010);
        do_clear();
        chk("t3_err_clear", err_clka, 0);

        // T4: overrun a full FIFO, including a push dropped while popping
        dout_ready_clka = 1'b0;
        d0 = done_cnt;
        start_burst(32);
        for (int i = 0; i < 16; i++) put_word(8'h40 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) put_word(8'hF0 + 8'(i), 1'b0, 1'b0);
        chk("t4_full_count", count_clka, 16);
        chk("t4_err", err_clka, 3'b001);
        chk("t4_req_full", data_req_clka, 0);
        dout_ready_clka = 1'b1;
        put_word(8'hEE, 1'b0, 1'b0);
        chk("t4_pushpop_full", count_clka, 15);
        drain();
        do_clear();
        chk("t4_err_clear", err_clka, 0);
        for (int i = 0; i < 16; i++) put_word(8'h60 + 8'(i), 1'b1, 1'b1);
        tick(); tick();
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_req_low", data_req_clka, 0);
        drain();

        // T5: collision during fill, including on the final write
        d0 = done_cnt;
        start_burst(4);
        put_word(8'hA0, 1'b1, 1'b1);
        put_word(8'hA1, 1'b1, 1'b1);
        burst_req_clka = 1'b1;
        burst_len_clka = 6'd9;
        put_word(8'hA2, 1'b1, 1'b1);
        chk("t5_err", err_clka, 3'b100);
        put_word(8'hA3, 1'b1, 1'b1);
        burst_req_clka = 1'b0;
        tick(); tick();
        chk("t5_no_restart", data_req_clka, 0);
        chk("t5_done_once", done_cnt - d0, 1);
        drain();
        do_clear();
        chk("t5_err_clear", err_clka, 0);

        // T6: asynchronous reset mid-burst
        dout_ready_clka = 1'b0;
        d0 = done_cnt;
        start_burst(8);
        for (int i = 0; i < 3; i++) put_word(8'h30 + 8'(i), 1'b1, 1'b0);
        chk("t6_pre_count", count_clka, 3);
        #2 reset_clka = 1'b1;
        #1;
        chk("t6_count", count_clka, 0);
        chk("t6_dout_valid", dout_valid_clka, 0);
        chk("t6_dout", dout_clka, 0);
        chk("t6_data_req", data_req_clka, 0);
        chk("t6_done", burst_done_clka, 0);
        #3 reset_clka = 1'b0;
        tick(); tick(); tick();
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_idle_req", data_req_clka, 0);

        // normal operation resumes after reset
        dout_ready_clka = 1'b1;
        d0 = done_cnt;
        start_burst(2);
        put_word(8'h55, 1'b1, 1'b1);
        put_word(8'h66, 1'b1, 1'b1);
        tick(); tick();
        chk("post_rst_done", done_cnt - d0, 1);
        drain();
        chk("final_err", err_clka, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
